// File: rtl/arb8_dec_ctrl.sv
// arb8_dec_ctrl: 8-way round-robin arbiter driving a 3-to-8 decoder.
// Ports: clk, rst (async high), req[7:0] in; sel[2:0], en_n, gnt[7:0], busy out.
module arb8_dec_ctrl #(
    parameter int MAX_HOLD = 4,
    parameter int HCW      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [2:0] sel,
    output logic       en_n,
    output logic [7:0] gnt,
    output logic       busy
);

    localparam logic [HCW-1:0] HLIM = HCW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t         r_state;
    state_t         w_state_nx;
    logic [2:0]     r_sel;
    logic [2:0]     w_sel_nx;
    logic [2:0]     r_ptr;
    logic [2:0]     w_ptr_nx;
    logic           r_en_n;
    logic           w_en_n_nx;
    logic [HCW-1:0] r_hcnt;
    logic [HCW-1:0] w_hcnt_nx;
    logic [7:0]     r_gnt;
    logic [7:0]     w_gnt_nx;

    logic           w_rel;
    logic           w_found;
    logic [2:0]     w_sptr;
    logic [2:0]     w_off;
    logic [2:0]     w_idx;
    logic [15:0]    w_dbl;
    logic [7:0]     w_rot;

    // On release the search starts just past the owner, so the owner
    // itself is examined last.
    always_comb begin
        w_rel   = (r_state == GRANT) &&
                  (!req[r_sel] || (r_hcnt == HLIM));
        w_sptr  = (r_state == GRANT) ? (r_sel + 3'd1) : r_ptr;
        w_dbl   = {req, req} >> w_sptr;
        w_rot   = w_dbl[7:0];
        w_found = |req;
        w_off   = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = 3'(k);
            end
        end
        w_idx = w_sptr + w_off;
    end

    always_comb begin
        w_state_nx = r_state;
        w_sel_nx   = r_sel;
        w_ptr_nx   = r_ptr;
        w_en_n_nx  = r_en_n;
        w_hcnt_nx  = r_hcnt;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nx = GRANT;
                    w_sel_nx   = w_idx;
                    w_en_n_nx  = 1'b0;
                    w_hcnt_nx  = '0;
                end
            end
            GRANT: begin
                if (!w_rel) begin
                    w_hcnt_nx = r_hcnt + 1'b1;
                end else begin
                    w_ptr_nx  = r_sel + 3'd1;
                    w_hcnt_nx = '0;
                    if (w_found) begin
                        w_sel_nx = w_idx;
                    end else begin
                        w_en_n_nx  = 1'b1;
                        w_state_nx = IDLE;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
        // Grant is registered from next-state values so it never glitches.
        w_gnt_nx = w_en_n_nx ? 8'h00 : (8'h01 << w_sel_nx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= 3'd0;
            r_ptr   <= 3'd0;
            r_en_n  <= 1'b1;
            r_hcnt  <= '0;
            r_gnt   <= 8'h00;
        end else begin
            r_state <= w_state_nx;
            r_sel   <= w_sel_nx;
            r_ptr   <= w_ptr_nx;
            r_en_n  <= w_en_n_nx;
            r_hcnt  <= w_hcnt_nx;
            r_gnt   <= w_gnt_nx;
        end
    end

    assign sel  = r_sel;
    assign en_n = r_en_n;
    assign gnt  = r_gnt;
    assign busy = ~r_en_n;

endmodule
